// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-nibble ALU sequencer.
// Holds the nibble width and the sequencer state encoding.
// Imported by alu_nibble_sequencer.
package alu_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage : alu_seq_pkg

// File: rtl/alu_nibble_sequencer.sv
// Sequences a wide operation through one 4-bit ALU slice, LS nibble first, chaining carry.
// Latency: NIBBLES+1 cycles from accept to res_valid; one nibble per cycle, no slice-loop registers.
// Backpressure: op_ready only in IDLE (no queueing); result held stable in DONE until res_ready.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [NIBBLE_W-1:0]          op_s,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  op_b,
  input  logic                         op_cin,
  output logic [NIBBLE_W-1:0]          alu_s,
  output logic [NIBBLE_W-1:0]          alu_a,
  output logic [NIBBLE_W-1:0]          alu_b,
  output logic                         alu_c_in,
  input  logic [NIBBLE_W-1:0]          alu_f,
  input  logic                         alu_c_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  res_f,
  output logic                         res_c_out,
  output logic                         res_zero,
  output logic                         busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  seq_state_t          state_q, state_d;
  logic [NIBBLE_W-1:0] s_q, s_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [W-1:0]        res_q, res_d;
  logic                res_c_q, res_c_d;

  // Next-state, operand capture, result collection and slice drive.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    res_d    = res_q;
    res_c_d  = res_c_q;
    alu_s    = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_c_in = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          s_d     = op_s;
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        alu_s    = s_q;
        alu_a    = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
        alu_b    = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
        alu_c_in = carry_q;
        res_d[idx_q*NIBBLE_W +: NIBBLE_W] = alu_f;
        carry_d  = alu_c_out;
        // Top nibble: latch the final carry and stop; the index is not wrapped.
        if (idx_q == LAST_IDX) begin
          res_c_d = alu_c_out;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      res_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      res_c_q <= res_c_d;
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_f     = res_q;
  assign res_c_out = res_c_q;
  assign res_zero  = (res_q == '0);

endmodule : alu_nibble_sequencer

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with NIBBLES=4 and a behavioural 4-bit slice beside it.
// Table-driven vectors plus hand-written backpressure and reset-abort sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_alu_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           op_valid = 1'b0;
  logic           op_ready;
  logic [3:0]     op_s = '0;
  logic [W-1:0]   op_a = '0;
  logic [W-1:0]   op_b = '0;
  logic           op_cin = 1'b0;
  logic [3:0]     alu_s, alu_a, alu_b;
  logic           alu_c_in;
  logic [3:0]     alu_f;
  logic           alu_c_out;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_f;
  logic           res_c_out;
  logic           res_zero;
  logic           busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_s(op_s), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_f(alu_f), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_f(res_f), .res_c_out(res_c_out), .res_zero(res_zero),
    .busy(busy)
  );

  // Behavioural arithmetic slice: 1001 A+B, 0110 A-B (A+~B+cin), 1100 A+A, others A^B.
  logic [4:0] slice_sum;
  logic [3:0] slice_nb;
  always_comb begin
    slice_nb  = ~alu_b;
    slice_sum = '0;
    case (alu_s)
      4'b1001: slice_sum = {1'b0, alu_a} + {1'b0, alu_b}    + {4'b0, alu_c_in};
      4'b0110: slice_sum = {1'b0, alu_a} + {1'b0, slice_nb} + {4'b0, alu_c_in};
      4'b1100: slice_sum = {1'b0, alu_a} + {1'b0, alu_a}    + {4'b0, alu_c_in};
      default: slice_sum = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_f     = slice_sum[3:0];
  assign alu_c_out = slice_sum[4];

  typedef struct {
    logic [3:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_f;
    logic         exp_c;
    logic         exp_z;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " op_ready"},  {31'b0, op_ready}, 32'd1);
    chk({tag, " busy"},      {31'b0, busy}, 32'd0);
    chk({tag, " res_valid"}, {31'b0, res_valid}, 32'd0);
    chk({tag, " res_f"},     {16'b0, res_f}, 32'h0);
    chk({tag, " res_c_out"}, {31'b0, res_c_out}, 32'd0);
    chk({tag, " res_zero"},  {31'b0, res_zero}, 32'd1);
    chk({tag, " alu_out"},   {19'b0, alu_s, alu_a, alu_b, alu_c_in}, 32'h0);
  endtask

  // Issue one op, check first-nibble drive, latency and result; optionally hold
  // backpressure for 'hold' cycles while a stray op_valid is offered.
  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int cnt;
    @(negedge clk);
    op_s = v.s; op_a = v.a; op_b = v.b; op_cin = v.cin; op_valid = 1'b1;
    chk({tag, " ready_before"}, {31'b0, op_ready}, 32'd1);
    @(posedge clk);
    #1 op_valid = 1'b0;
    op_a = '0; op_b = '0; op_s = '0; op_cin = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        chk({tag, " nib0_drive"}, {19'b0, alu_s, alu_a, alu_b, alu_c_in},
            {19'b0, v.s, v.a[3:0], v.b[3:0], v.cin});
        chk({tag, " busy_run"}, {30'b0, busy, op_ready}, 32'b10);
      end
    end while (!res_valid && cnt < 20);
    chk({tag, " latency"}, cnt, NIB + 1);
    chk({tag, " res_f"}, {16'b0, res_f}, {16'b0, v.exp_f});
    chk({tag, " res_c_out"}, {31'b0, res_c_out}, {31'b0, v.exp_c});
    chk({tag, " res_zero"}, {31'b0, res_zero}, {31'b0, v.exp_z});
    for (int k = 0; k < hold; k++) begin
      op_valid = 1'b1; op_s = 4'b1001; op_a = 16'h1111; op_b = 16'h1111;
      @(negedge clk);
      chk({tag, " hold_state"}, {29'b0, res_valid, op_ready, res_c_out}, {29'b0, 1'b1, 1'b0, v.exp_c});
      chk({tag, " hold_res_f"}, {16'b0, res_f}, {16'b0, v.exp_f});
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk({tag, " back_idle"}, {30'b0, op_ready, res_valid}, 32'b10);
  endtask

  initial begin
    vecs[0] = '{4'b1001, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{4'b1001, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{4'b0110, 16'h5000, 16'h1000, 1'b1, 16'h4000, 1'b1, 1'b0};
    vecs[3] = '{4'b1100, 16'h8421, 16'h0000, 1'b0, 16'h0842, 1'b1, 1'b0};
    vecs[4] = '{4'b1001, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[5] = '{4'b0110, 16'h1000, 16'h2000, 1'b1, 16'hF000, 1'b0, 1'b0};
    vecs[6] = '{4'b1001, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{4'b1001, 16'hA5C3, 16'h5A3C, 1'b1, 16'h0000, 1'b1, 1'b1};

    // Reset state
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stray_ready", {31'b0, res_valid}, 32'd0);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Backpressure: 10 cycles of res_ready low with a stray op_valid, then a clean op
    run_vec(vecs[0], 10, "bp");
    run_vec(vecs[2], 0, "bp_next");

    // Reset mid-RUN after two nibbles have been captured
    @(negedge clk);
    op_s = 4'b1001; op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrun_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrun_no_valid_in_rst", {31'b0, res_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrun_no_valid_after", {30'b0, res_valid, busy}, 32'd0);
    end
    begin
      vec_t v;
      v = '{4'b1001, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      run_vec(v, 0, "after_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_nibble_sequencer
